mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- Receiving end of the MEM-stage output bundle: register write (wd/wreg/wdata) plus HI/LO write (whilo/hi/lo).
- Contains the MEM/WB pipeline latch, the 32-entry GPR file and the HI/LO register pair.
- Provides two GPR read ports for ID and a HI/LO read port for EX, each with write-through bypass from the WB write.
- Sits between the mem stage and the ID/EX read logic.

Parameters:
- DATA_W, 32, GPR/HI/LO data width.
- ADDR_W, 5, GPR address width; file depth is 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- mem_wd  in  ADDR_W  destination GPR from mem stage.
- mem_wreg  in  1  GPR write enable from mem stage.
- mem_wdata  in  DATA_W  GPR write data from mem stage.
- mem_whilo  in  1  HI/LO write enable from mem stage.
- mem_hi  in  DATA_W  HI write data.
- mem_lo  in  DATA_W  LO write data.
- stall_i  in  1  hold the MEM/WB latch contents.
- flush_i  in  1  load a bubble into the MEM/WB latch.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.
- wb_busy  out  1  latch holds a valid write (wb_wreg or wb_whilo); registered.

Behaviour:

Reset (rst==0 at clk edge):
- MEM/WB latch cleared: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_whilo=0, wb_hi=0, wb_lo=0.
- All GPRs=0; HI=LO=0; wb_busy=0.
- While rst==0, rdata1/rdata2/hi_o/lo_o are forced to 0 combinationally.
- Reset in the middle of a stall or pending write discards the pending write.

MEM/WB latch (per edge, priority order):
1. Reset.
2. flush_i=1: load a bubble (all fields 0). Flush wins over stall.
3. stall_i=1: hold the current contents.
4. Otherwise: capture all six mem_* inputs.

Write-back:
- Occurs at the edge after capture, with no further conditions.
- If wb_wreg=1 and wb_wd!=0: GPR[wb_wd] <= wb_wdata.
- If wb_whilo=1: HI <= wb_hi and LO <= wb_lo.
- While stall_i holds the latch, the same write repeats every edge. This is idempotent and legal.

Latency:
- mem_* presented in cycle N is latched at edge N and committed to the array at edge N+1.
- The value is visible on the read ports from cycle N+1 via bypass, and from the array from cycle N+2.

GPR read, per port, combinational, in priority order:
1. rst==0 -> 0.
2. raddr==0 -> 0.
3. re=1 and raddr==wb_wd and wb_wreg=1 -> wb_wdata (bypass).
4. re=1 -> GPR[raddr].
5. re=0 -> 0.

HI/LO read:
- hi_o = wb_whilo ? wb_hi : HI.
- lo_o = wb_whilo ? wb_lo : LO.

Register 0:
- Never written and always reads 0, even if wb_wd==0 with wb_wreg=1.

Simultaneous events:
- Both read ports may target the same address and both receive the same value.
- A GPR write and a HI/LO write in the same cycle are independent and both commit.

Test Plan:
- Reset: preload GPR5 and HI/LO with nonzero values, drive rst=0 for one edge -> rdata1(raddr1=5)=0, hi_o=lo_o=0, wb_busy=0. After rst=1, no stale writes occur.
- Write/bypass: cycle N drive mem_wd=3, mem_wreg=1, mem_wdata=0xDEADBEEF -> cycle N+1 rdata1(re1=1, raddr1=3)=0xDEADBEEF via bypass. Cycle N+2 the same value comes from the array with mem_wreg=0.
- R0 protection: mem_wd=0, mem_wreg=1, mem_wdata=0x12345678 -> rdata1/rdata2 at address 0 are 0 in all following cycles.
- HI/LO: mem_whilo=1, mem_hi=0x1, mem_lo=0xFFFF0000 -> hi_o=0x1 and lo_o=0xFFFF0000 from cycle N+1 and thereafter. With mem_whilo=0 later, the values persist.
- Stall/flush: latch holds write {wd=7, data=0xA5A5A5A5}; assert stall_i for 3 cycles with mem_wdata=0x11111111 -> GPR7 stays 0xA5A5A5A5. Assert stall_i=1 and flush_i=1 together -> latch becomes a bubble and wb_busy=0 next cycle.
- Dual read: re1=re2=1 with raddr1=raddr2=9 while the latch writes 9 with 0xCAFEF00D -> both ports return 0xCAFEF00D. With re2=0, rdata2=0.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline latch feeding the 32-entry GPR file and the HI/LO pair.
// Read ports for ID (GPR) and EX (HI/LO) bypass the pending write-back value.
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              wb_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;

    logic [DATA_W-1:0] gpr [0:DEPTH-1];
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    // Flush beats stall so a squashed instruction can never be held in place.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
            wb_whilo <= 1'b0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_busy  <= 1'b0;
        end else if (!stall_i) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
            wb_busy  <= mem_wreg | mem_whilo;
        end
    end

    // While stalled the same write commits every edge, which is harmless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (wb_whilo) begin
            hi_reg <= wb_hi;
            lo_reg <= wb_lo;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (re1 && wb_wreg && (raddr1 == wb_wd)) begin
            rdata1 = wb_wdata;
        end else if (re1) begin
            rdata1 = gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (re2 && wb_wreg && (raddr2 == wb_wd)) begin
            rdata2 = wb_wdata;
        end else if (re2) begin
            rdata2 = gpr[raddr2];
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst) begin
            hi_o = wb_whilo ? wb_hi : hi_reg;
            lo_o = wb_whilo ? wb_lo : lo_reg;
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: reset, bypass, R0, HI/LO, stall/flush, dual read.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        stall_i;
    logic        flush_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        wb_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .stall_i(stall_i), .flush_i(flush_i),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .wb_busy(wb_busy)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_wd    = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
        mem_whilo = 1'b0;
        mem_hi    = '0;
        mem_lo    = '0;
    endtask

    task automatic test_reset();
        mem_wd = 5; mem_wreg = 1'b1; mem_wdata = 32'h0000_0055;
        mem_whilo = 1'b1; mem_hi = 32'h0000_00AA; mem_lo = 32'h0000_00BB;
        cycle();
        clear_mem();
        cycle();
        re1 = 1'b1; raddr1 = 5; #1;
        checks++;
        if (rdata1 !== 32'h55) begin errors++; $display("[TB] FAIL preload_gpr5 got %h exp %h", rdata1, 32'h55); end
        checks++;
        if (hi_o !== 32'hAA || lo_o !== 32'hBB) begin errors++; $display("[TB] FAIL preload_hilo got %h/%h exp aa/bb", hi_o, lo_o); end
        // Leave a pending write in the latch, then reset over it.
        mem_wd = 5; mem_wreg = 1'b1; mem_wdata = 32'h0000_0077;
        cycle();
        clear_mem();
        rst = 1'b0; #1;
        checks++;
        if (rdata1 !== 32'h0 || hi_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_comb_force got %h/%h exp 0/0", rdata1, hi_o); end
        cycle();
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata1 got %h exp 0", rdata1); end
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_hilo got %h/%h exp 0/0", hi_o, lo_o); end
        checks++;
        if (wb_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", wb_busy); end
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_no_stale got %h/%h/%h exp 0/0/0", rdata1, hi_o, lo_o);
        end
    endtask

    task automatic test_write_bypass();
        mem_wd = 3; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
        cycle();
        clear_mem();
        re1 = 1'b1; raddr1 = 3; #1;
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bypass_rdata1 got %h exp deadbeef", rdata1); end
        checks++;
        if (wb_busy !== 1'b1) begin errors++; $display("[TB] FAIL bypass_busy got %b exp 1", wb_busy); end
        cycle();
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL array_rdata1 got %h exp deadbeef", rdata1); end
        checks++;
        if (wb_busy !== 1'b0) begin errors++; $display("[TB] FAIL array_busy got %b exp 0", wb_busy); end
        re1 = 1'b0; #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL re1_low got %h exp 0", rdata1); end
    endtask

    task automatic test_r0();
        mem_wd = 0; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
        cycle();
        clear_mem();
        re1 = 1'b1; raddr1 = 0; re2 = 1'b1; raddr2 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                errors++; $display("[TB] FAIL r0_read[%0d] got %h/%h exp 0/0", i, rdata1, rdata2);
            end
            cycle();
        end
    endtask

    task automatic test_hilo();
        mem_whilo = 1'b1; mem_hi = 32'h0000_0001; mem_lo = 32'hFFFF_0000;
        cycle();
        clear_mem();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_0000) begin
                errors++; $display("[TB] FAIL hilo[%0d] got %h/%h exp 1/ffff0000", i, hi_o, lo_o);
            end
            cycle();
        end
    endtask

    task automatic test_stall_flush();
        mem_wd = 7; mem_wreg = 1'b1; mem_wdata = 32'hA5A5_A5A5;
        cycle();
        stall_i = 1'b1; mem_wdata = 32'h1111_1111;
        re1 = 1'b1; raddr1 = 7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (rdata1 !== 32'hA5A5_A5A5 || wb_busy !== 1'b1) begin
                errors++; $display("[TB] FAIL stall_hold[%0d] got %h busy %b exp a5a5a5a5 busy 1", i, rdata1, wb_busy);
            end
        end
        flush_i = 1'b1;
        cycle();
        checks++;
        if (wb_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b exp 0", wb_busy); end
        checks++;
        if (rdata1 !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL flush_array got %h exp a5a5a5a5", rdata1); end
        flush_i = 1'b0; stall_i = 1'b0;
        clear_mem();
        cycle();
        checks++;
        if (rdata1 !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL after_flush got %h exp a5a5a5a5", rdata1); end
    endtask

    task automatic test_dual_read();
        mem_wd = 9; mem_wreg = 1'b1; mem_wdata = 32'hCAFE_F00D;
        mem_whilo = 1'b1; mem_hi = 32'h1357_9BDF; mem_lo = 32'h2468_ACE0;
        cycle();
        clear_mem();
        re1 = 1'b1; raddr1 = 9; re2 = 1'b1; raddr2 = 9; #1;
        checks++;
        if (rdata1 !== 32'hCAFE_F00D || rdata2 !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL dual_bypass got %h/%h exp cafef00d/cafef00d", rdata1, rdata2);
        end
        re2 = 1'b0; #1;
        checks++;
        if (rdata2 !== 32'h0 || rdata1 !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL dual_re2_low got %h/%h exp cafef00d/0", rdata1, rdata2);
        end
        cycle();
        re2 = 1'b1; #1;
        checks++;
        if (rdata1 !== 32'hCAFE_F00D || rdata2 !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL dual_array got %h/%h exp cafef00d/cafef00d", rdata1, rdata2);
        end
        checks++;
        if (hi_o !== 32'h1357_9BDF || lo_o !== 32'h2468_ACE0) begin
            errors++; $display("[TB] FAIL dual_hilo got %h/%h exp 13579bdf/2468ace0", hi_o, lo_o);
        end
        raddr2 = 3; #1;
        checks++;
        if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL port2_addr3 got %h exp deadbeef", rdata2); end
    endtask

    initial begin
        rst = 1'b0;
        clear_mem();
        stall_i = 1'b0; flush_i = 1'b0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        cycle();
        cycle();
        rst = 1'b1;
        test_reset();
        test_write_bypass();
        test_r0();
        test_hilo();
        test_stall_flush();
        test_dual_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
